// File: rtl/fighter_player.sv
// Single-player turn resolver for an N-slot fighting arena.
// Tracks a one-hot position, health with await-driven regen, and a sticky dead flag.
module fighter_player #(
  parameter int NUM_POS     = 5,
  parameter int SIDE        = 0,
  parameter int HEALTH_W    = 2,
  parameter int MAX_HEALTH  = 3,
  parameter int KICK_DMG    = 1,
  parameter int PUNCH_DMG   = 2,
  parameter int KICK_RANGE  = 2,
  parameter int PUNCH_RANGE = 1,
  parameter int REGEN_WAITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                action_enable,
  input  logic                game_over,
  input  logic [2:0]          my_action,
  input  logic [2:0]          opp_action,
  input  logic [NUM_POS-1:0]  opp_pos,
  output logic [NUM_POS-1:0]  pos,
  output logic [HEALTH_W-1:0] health,
  output logic                dead,
  output logic                turn_done
);

  localparam int IDX_W = (NUM_POS > 2) ? $clog2(NUM_POS) : 1;
  localparam int CNT_W = (REGEN_WAITS > 1) ? $clog2(REGEN_WAITS + 1) : 1;

  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_POS - 1);
  localparam logic [NUM_POS-1:0]  ONE_POS    = NUM_POS'(1);
  localparam logic [NUM_POS-1:0]  RESET_POS  = (SIDE != 0) ? (ONE_POS << (NUM_POS - 1)) : ONE_POS;
  localparam logic [HEALTH_W-1:0] MAX_H      = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W:0]   KICK_D     = (HEALTH_W + 1)'(KICK_DMG);
  localparam logic [HEALTH_W:0]   PUNCH_D    = (HEALTH_W + 1)'(PUNCH_DMG);
  localparam logic [31:0]         KICK_RNG   = 32'(KICK_RANGE);
  localparam logic [31:0]         PUNCH_RNG  = 32'(PUNCH_RANGE);
  localparam logic [CNT_W-1:0]    REGEN_LAST = CNT_W'(REGEN_WAITS - 1);

  localparam logic [2:0] ACT_KICK  = 3'b000;
  localparam logic [2:0] ACT_PUNCH = 3'b001;
  localparam logic [2:0] ACT_AWAIT = 3'b010;
  localparam logic [2:0] ACT_JUMP  = 3'b011;

  logic                en_q, en_d;
  logic [NUM_POS-1:0]  pos_q, pos_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic                dead_q, dead_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    wait_q, wait_d;

  logic                fire_s;
  logic [IDX_W-1:0]    my_idx_s;
  logic [IDX_W-1:0]    opp_idx_s;
  logic                opp_here_s;
  logic [IDX_W-1:0]    dist_s;
  logic [31:0]         dist32_s;
  logic [IDX_W-1:0]    tgt_s;
  logic                kick_hit_s;
  logic                punch_hit_s;
  logic [HEALTH_W:0]   dmg_s;
  logic [HEALTH_W:0]   health_ext_s;
  logic [HEALTH_W-1:0] hit_health_s;

  assign fire_s = action_enable & ~en_q & ~game_over & ~dead_q;

  // Own index from one-hot pos, opponent index as its lowest set bit.
  always_comb begin
    my_idx_s  = '0;
    opp_idx_s = '0;
    for (int i = 0; i < NUM_POS; i++) begin
      my_idx_s = my_idx_s | (pos_q[i] ? IDX_W'(i) : '0);
    end
    for (int i = NUM_POS - 1; i >= 0; i--) begin
      opp_idx_s = opp_pos[i] ? IDX_W'(i) : opp_idx_s;
    end
    opp_here_s = |opp_pos;
    dist_s     = (my_idx_s > opp_idx_s) ? (my_idx_s - opp_idx_s) : (opp_idx_s - my_idx_s);
    dist32_s   = {{(32 - IDX_W){1'b0}}, dist_s};
  end

  // Step one slot at a time so an opponent blocks both entry and crossing.
  always_comb begin
    tgt_s = my_idx_s;
    for (int k = 0; k < 2; k++) begin
      if (my_action[2] && (k == 0 || my_action[0])) begin
        if (my_action[1]) begin
          tgt_s = (tgt_s == LAST_IDX || (opp_here_s && opp_idx_s == tgt_s + IDX_W'(1)))
                  ? tgt_s : tgt_s + IDX_W'(1);
        end else begin
          tgt_s = (tgt_s == '0 || (opp_here_s && opp_idx_s == tgt_s - IDX_W'(1)))
                  ? tgt_s : tgt_s - IDX_W'(1);
        end
      end else begin
        tgt_s = tgt_s;
      end
    end
  end

  // Incoming damage on pre-move distance, with jump dodge and same-attack clash.
  always_comb begin
    kick_hit_s   = opp_here_s && (opp_action == ACT_KICK) && (dist32_s <= KICK_RNG) &&
                   (my_action != ACT_JUMP) && (my_action != ACT_KICK);
    punch_hit_s  = opp_here_s && (opp_action == ACT_PUNCH) && (dist32_s <= PUNCH_RNG) &&
                   (my_action != ACT_PUNCH);
    dmg_s        = kick_hit_s ? KICK_D : (punch_hit_s ? PUNCH_D : '0);
    health_ext_s = {1'b0, health_q};
    hit_health_s = (health_ext_s >= dmg_s) ? HEALTH_W'(health_ext_s - dmg_s) : '0;
  end

  // Turn resolution: everything holds unless a turn fires this cycle.
  always_comb begin
    en_d     = action_enable;
    pos_d    = pos_q;
    health_d = health_q;
    dead_d   = dead_q;
    wait_d   = wait_q;
    done_d   = 1'b0;
    if (fire_s) begin
      pos_d    = ONE_POS << tgt_s;
      health_d = hit_health_s;
      done_d   = 1'b1;
      if ((my_action == ACT_AWAIT) && !(kick_hit_s || punch_hit_s)) begin
        if (wait_q == REGEN_LAST) begin
          wait_d   = '0;
          health_d = (health_q < MAX_H) ? health_q + HEALTH_W'(1) : health_q;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end else begin
        wait_d = '0;
      end
      dead_d = (health_d == '0);
    end else begin
      done_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q     <= 1'b1;
      pos_q    <= RESET_POS;
      health_q <= MAX_H;
      dead_q   <= 1'b0;
      done_q   <= 1'b0;
      wait_q   <= '0;
    end else begin
      en_q     <= en_d;
      pos_q    <= pos_d;
      health_q <= health_d;
      dead_q   <= dead_d;
      done_q   <= done_d;
      wait_q   <= wait_d;
    end
  end

  assign pos       = pos_q;
  assign health    = health_q;
  assign dead      = dead_q;
  assign turn_done = done_q;

endmodule

// File: tb/tb_fighter_player.sv
// Directed bench for fighter_player (SIDE=1, 5 slots) against an integer-level turn model.
module tb_fighter_player;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         action_enable;
  logic         game_over;
  logic [2:0]   my_action;
  logic [2:0]   opp_action;
  logic [N-1:0] opp_pos;
  logic [N-1:0] pos;
  logic [1:0]   health;
  logic         dead;
  logic         turn_done;

  always #5 clk = ~clk;

  fighter_player #(.NUM_POS(N), .SIDE(1)) dut (
    .clk(clk), .reset(reset), .action_enable(action_enable), .game_over(game_over),
    .my_action(my_action), .opp_action(opp_action), .opp_pos(opp_pos),
    .pos(pos), .health(health), .dead(dead), .turn_done(turn_done)
  );

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  bit chk_on = 1'b0;

  int m_pos, m_health, m_wait;
  bit m_dead, m_done, m_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer slot index, health and regen count.
  always @(posedge clk) begin : model
    int p, h, w, oi, d, dmg, t;
    bit fire;
    if (!reset) begin
      m_pos <= N - 1; m_health <= 3; m_wait <= 0;
      m_dead <= 1'b0; m_done <= 1'b0; m_en <= 1'b1;
    end else begin
      fire = action_enable && !m_en && !game_over && !m_dead;
      m_en <= action_enable;
      m_done <= fire;
      if (fire) begin
        p = m_pos; h = m_health; w = m_wait;
        oi = -1;
        for (int i = N - 1; i >= 0; i--) if (opp_pos[i]) oi = i;
        d = (oi < 0) ? 0 : ((p > oi) ? p - oi : oi - p);
        dmg = 0;
        if (oi >= 0 && opp_action == 3'd0 && d <= 2 && my_action != 3'd3 && my_action != 3'd0) dmg = 1;
        if (oi >= 0 && opp_action == 3'd1 && d <= 1 && my_action != 3'd1) dmg = 2;
        case (my_action)
          3'd4, 3'd5: begin
            t = p - ((my_action == 3'd5) ? 2 : 1);
            if (t < 0) t = 0;
            if (oi >= 0 && oi < p && t <= oi) t = oi + 1;
          end
          3'd6, 3'd7: begin
            t = p + ((my_action == 3'd7) ? 2 : 1);
            if (t > N - 1) t = N - 1;
            if (oi > p && t >= oi) t = oi - 1;
          end
          default: t = p;
        endcase
        h = (h > dmg) ? h - dmg : 0;
        if (my_action == 3'd2 && dmg == 0) begin
          w = w + 1;
          if (w == 2) begin
            w = 0;
            if (h < 3) h = h + 1;
          end
        end else begin
          w = 0;
        end
        m_pos <= t; m_health <= h; m_wait <= w; m_dead <= (h == 0);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pos", pos, 32'(1) << m_pos);
      chk("health", health, m_health);
      chk("dead", dead, m_dead);
      chk("turn_done", turn_done, m_done);
      if (turn_done === 1'b1) pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [2:0] m, input logic [2:0] o, input logic [N-1:0] op);
    my_action = m; opp_action = o; opp_pos = op;
    action_enable = 1'b1;
    tick(1);
    action_enable = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  localparam logic [2:0] KICK = 3'd0, PUNCH = 3'd1, AWAIT = 3'd2, JUMP = 3'd3;
  localparam logic [2:0] LEFT1 = 3'd4, LEFT2 = 3'd5, RIGHT1 = 3'd6, RIGHT2 = 3'd7;

  int p0;

  initial begin
    reset = 1'b0; action_enable = 1'b1; game_over = 1'b0;
    my_action = AWAIT; opp_action = AWAIT; opp_pos = '0;
    tick(1);
    chk_on = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(3);
    chk("rst_pos", pos, 32'b10000);
    chk("rst_health", health, 3);
    chk("rst_dead", dead, 0);
    chk("rst_no_turn", pulses, 0);

    // Held enable: exactly one turn per rising edge
    my_action = LEFT1; opp_action = AWAIT; opp_pos = 5'b00001;
    action_enable = 1'b0; tick(1);
    p0 = pulses;
    action_enable = 1'b1; tick(4);
    action_enable = 1'b0; tick(1);
    chk("held_pos", pos, 32'b01000);
    chk("held_pulses", pulses - p0, 1);
    strobe(LEFT1, AWAIT, 5'b00001);
    chk("left1_pos", pos, 32'b00100);
    strobe(RIGHT2, AWAIT, 5'b10000);
    chk("right2_block", pos, 32'b01000);

    // Collision and edge clamping
    do_reset();
    strobe(LEFT2, AWAIT, 5'b00100);
    chk("left2_adj", pos, 32'b01000);
    strobe(LEFT2, AWAIT, 5'b00100);
    chk("left2_stay", pos, 32'b01000);
    strobe(LEFT2, AWAIT, 5'b00000);
    strobe(LEFT2, AWAIT, 5'b00000);
    chk("left2_to0", pos, 32'b00001);
    strobe(LEFT2, AWAIT, 5'b00000);
    chk("left2_edge", pos, 32'b00001);

    // Damage, dodge, clash and death
    strobe(AWAIT, PUNCH, 5'b00010);
    chk("punch_hit", health, 1);
    strobe(JUMP, KICK, 5'b00010);
    chk("jump_dodge", health, 1);
    strobe(PUNCH, KICK, 5'b00010);
    chk("kick_kill", health, 0);
    chk("dead_set", dead, 1);
    p0 = pulses;
    strobe(RIGHT1, AWAIT, 5'b00000);
    strobe(AWAIT, AWAIT, 5'b00000);
    chk("dead_frozen_pos", pos, 32'b00001);
    chk("dead_no_pulse", pulses - p0, 0);
    reset = 1'b0; tick(1);
    reset = 1'b1;
    chk("dead_reset_h", health, 3);
    chk("dead_reset_d", dead, 0);
    chk("dead_reset_p", pos, 32'b10000);
    tick(1);

    // Regen
    strobe(AWAIT, KICK, 5'b00100);
    chk("kick_r2", health, 2);
    strobe(AWAIT, AWAIT, 5'b00100);
    chk("regen_1st", health, 2);
    strobe(AWAIT, AWAIT, 5'b00100);
    chk("regen_2nd", health, 3);
    strobe(AWAIT, KICK, 5'b00100);
    strobe(AWAIT, AWAIT, 5'b00100);
    strobe(KICK, AWAIT, 5'b00100);
    strobe(AWAIT, AWAIT, 5'b00100);
    chk("regen_cleared", health, 2);
    strobe(AWAIT, AWAIT, 5'b00100);
    chk("regen_after", health, 3);
    strobe(AWAIT, KICK, 5'b00100);
    strobe(AWAIT, AWAIT, 5'b00100);
    strobe(AWAIT, KICK, 5'b00100);
    strobe(AWAIT, AWAIT, 5'b00100);
    chk("regen_hit_clr", health, 1);
    strobe(AWAIT, PUNCH, 5'b00100);
    chk("punch_out_rng", health, 2);

    // game_over freeze and edge consumption
    game_over = 1'b1;
    p0 = pulses;
    strobe(LEFT1, AWAIT, 5'b00000);
    chk("go_pos", pos, 32'b10000);
    my_action = LEFT1; action_enable = 1'b1; tick(1);
    game_over = 1'b0; tick(2);
    action_enable = 1'b0; tick(1);
    chk("go_consumed", pos, 32'b10000);
    chk("go_pulses", pulses - p0, 0);
    strobe(LEFT1, AWAIT, 5'b00000);
    chk("go_after", pos, 32'b01000);

    // Reset overriding a turn, then reset one cycle after a firing edge
    my_action = LEFT1; action_enable = 1'b1; reset = 1'b0; tick(1);
    reset = 1'b1; action_enable = 1'b0; tick(1);
    chk("rst_override", pos, 32'b10000);
    my_action = LEFT1; action_enable = 1'b1; tick(1);
    reset = 1'b0; action_enable = 1'b0; tick(1);
    chk("rst_mid_done", turn_done, 0);
    chk("rst_mid_pos", pos, 32'b10000);
    reset = 1'b1; tick(2);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
